// File: rtl/adc_oversample_avg.sv
// Flash ADC back-end: resynchronise the code, sum 2^LOG2_N samples,
// track block min/max, and hand results out through a valid/ready register.
module adc_oversample_avg #(
    parameter int CODE_W = 3,
    parameter int LOG2_N = 4,
    parameter int SUM_W  = CODE_W + LOG2_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] adc_code,
    input  logic              enable,
    input  logic              sample_en,
    input  logic              out_ready,
    input  logic              clr_ovr,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_sum,
    output logic [CODE_W-1:0] out_min,
    output logic [CODE_W-1:0] out_max,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    localparam logic [LOG2_N-1:0] LAST = '1;

    state_t              r_state;
    logic [CODE_W-1:0]   r_sync1;
    logic [CODE_W-1:0]   r_sync2;
    logic [LOG2_N-1:0]   r_count;
    logic [SUM_W-1:0]    r_acc;
    logic [CODE_W-1:0]   r_min;
    logic [CODE_W-1:0]   r_max;
    logic                r_valid;
    logic [SUM_W-1:0]    r_sum;
    logic [CODE_W-1:0]   r_omin;
    logic [CODE_W-1:0]   r_omax;
    logic                r_ovr;

    logic                w_take;
    logic                w_first;
    logic                w_done;
    logic                w_load;
    logic                w_ovr_evt;
    logic [SUM_W-1:0]    w_code_ext;
    logic [SUM_W-1:0]    w_acc_nxt;
    logic [CODE_W-1:0]   w_min_nxt;
    logic [CODE_W-1:0]   w_max_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= adc_code;
            r_sync2 <= r_sync1;
        end
    end

    // The first sample of a block loads directly, so no clear cycle is needed
    assign w_take     = (r_state == S_ACCUM) && enable && sample_en;
    assign w_first    = (r_count == '0);
    assign w_done     = w_take && (r_count == LAST);
    assign w_code_ext = SUM_W'(r_sync2);
    assign w_acc_nxt  = w_first ? w_code_ext : r_acc + w_code_ext;
    assign w_min_nxt  = (w_first || r_sync2 < r_min) ? r_sync2 : r_min;
    assign w_max_nxt  = (w_first || r_sync2 > r_max) ? r_sync2 : r_max;
    assign w_load     = w_done && (!r_valid || out_ready);
    assign w_ovr_evt  = w_done && r_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_min   <= '0;
            r_max   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    r_acc   <= '0;
                    if (enable)
                        r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end else if (sample_en) begin
                        r_acc   <= w_acc_nxt;
                        r_min   <= w_min_nxt;
                        r_max   <= w_max_nxt;
                        r_count <= r_count + LOG2_N'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_omin  <= '0;
            r_omax  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_sum   <= w_acc_nxt;
                r_omin  <= w_min_nxt;
                r_omax  <= w_max_nxt;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_ovr_evt)
                r_ovr <= 1'b1;
            else if (clr_ovr)
                r_ovr <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign out_min   = r_omin;
    assign out_max   = r_omax;
    assign overrun   = r_ovr;
    assign busy      = (r_state == S_ACCUM) && (r_count != '0);

endmodule

// File: tb/tb_adc_oversample_avg.sv
// Scoreboard bench for adc_oversample_avg: directed blocks with
// hand-computed sums, checked by a handshake-driven monitor.
module tb_adc_oversample_avg;

    logic       clk;
    logic       rst_n;
    logic [2:0] adc_code;
    logic       enable;
    logic       sample_en;
    logic       out_ready;
    logic       clr_ovr;
    logic       out_valid;
    logic [6:0] out_sum;
    logic [2:0] out_min;
    logic [2:0] out_max;
    logic       overrun;
    logic       busy;

    typedef struct packed {
        logic [6:0] sum;
        logic [2:0] mn;
        logic [2:0] mx;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;

    adc_oversample_avg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_code  (adc_code),
        .enable    (enable),
        .sample_en (sample_en),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_min   (out_min),
        .out_max   (out_max),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int mn, input int mx);
        exp_t e;
        e.sum = 7'(s);
        e.mn  = 3'(mn);
        e.mx  = 3'(mx);
        q.push_back(e);
    endtask

    task automatic strobes(input int n);
        sample_en = 1'b1;
        repeat (n) tick();
        sample_en = 1'b0;
    endtask

    task automatic set_code(input int c);
        adc_code = 3'(c);
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL result: unexpected sum=%0d min=%0d max=%0d",
                         out_sum, out_min, out_max);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_sum != e.sum || out_min != e.mn || out_max != e.mx) begin
                    n_bad++;
                    $display("FAIL result: got sum=%0d min=%0d max=%0d expected sum=%0d min=%0d max=%0d",
                             out_sum, out_min, out_max, e.sum, e.mn, e.mx);
                end
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        adc_code  = '0;
        enable    = 1'b0;
        sample_en = 1'b0;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        repeat (3) tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_sum", int'(out_sum), 0);
        check("rst_ovr", int'(overrun), 0);
        rst_n = 1'b1;
        adc_code = 3'd6;
        repeat (20) begin
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            tick();
        end
        check("idle_valid", int'(out_valid), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_sum", int'(out_sum), 0);
        check("idle_minmax", int'({out_min, out_max}), 0);

        // constant code 5
        out_ready = 1'b1;
        set_code(5);
        enable = 1'b1;
        tick();
        push(80, 5, 5);
        strobes(15);
        check("const_lat15", int'(out_valid), 0);
        strobes(1);
        check("const_lat16", int'(out_valid), 1);
        tick();
        check("const_fall", int'(out_valid), 0);

        // ramp with gaps
        push(56, 0, 7);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 8; c++) begin
                adc_code = 3'(c);
                tick();
                tick();
                strobes(1);
            end
        end
        tick();
        check("ramp_fall", int'(out_valid), 0);

        // back-pressure and overrun
        out_ready = 1'b0;
        set_code(7);
        push(112, 7, 7);
        strobes(16);
        check("bp_valid", int'(out_valid), 1);
        strobes(15);
        check("bp_ovr31", int'(overrun), 0);
        strobes(1);
        check("bp_ovr32", int'(overrun), 1);
        check("bp_keep", int'(out_sum), 112);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("bp_clr", int'(overrun), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drain", int'(out_valid), 0);

        // transfer coincident with completion
        push(112, 7, 7);
        strobes(16);
        set_code(3);
        strobes(15);
        push(48, 3, 3);
        sample_en = 1'b1;
        out_ready = 1'b1;
        tick();
        sample_en = 1'b0;
        check("coin_valid", int'(out_valid), 1);
        check("coin_ovr", int'(overrun), 0);
        tick();
        check("coin_fall", int'(out_valid), 0);

        // abort a partial block
        set_code(7);
        strobes(10);
        check("abort_busy", int'(busy), 1);
        enable = 1'b0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("abort_idle", int'(busy), 0);
        enable = 1'b1;
        set_code(2);
        push(32, 2, 2);
        strobes(16);
        tick();
        check("abort_fall", int'(out_valid), 0);

        // async reset mid-block with a held result
        out_ready = 1'b0;
        strobes(16);
        strobes(5);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_sum", int'(out_sum), 0);
        check("arst_minmax", int'({out_min, out_max}), 0);
        check("arst_busy", int'(busy), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
